// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD add/subtract engine:
// controller states, BCD correction constants and a digit validity check.
package bcd_pkg;

  // Controller states of the sequential engine
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } bcdState_t;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX     = 4'd9;
  // Correction added after a decimal carry out of a digit
  localparam logic [4:0] BCD_ADJ_ADD = 5'd6;
  // Correction added after a decimal borrow into a digit
  localparam logic [4:0] BCD_ADJ_SUB = 5'd10;

  // True when a 4-bit nibble holds a legal decimal digit
  function automatic logic digitValid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_unit.sv
// Single-digit BCD add/subtract cell. Purely combinational; the sequential
// engine feeds it one digit pair per clock plus the running carry/borrow.
// mode=0: digit = a_i + b_i + cin, cout = decimal carry.
// mode=1: digit = a_i - b_i - cin, cout = decimal borrow.
module bcd_digit_unit
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       mode,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] sumRaw;
  logic [4:0] diffRaw;

  // Binary sum with decimal carry correction
  function automatic logic [4:0] addAdjust(input logic [4:0] s);
    logic [4:0] fixed;
    fixed = s;
    if (s > {1'b0, BCD_MAX}) begin
      fixed = s + BCD_ADJ_ADD;
      fixed[4] = 1'b1;
    end else begin
      fixed[4] = 1'b0;
    end
    return fixed;
  endfunction

  // Two's-complement difference with decimal borrow correction; bit 4 of
  // the raw difference is the borrow indication
  function automatic logic [4:0] subAdjust(input logic [4:0] d);
    logic [4:0] fixed;
    fixed = d;
    if (d[4]) begin
      fixed = d + BCD_ADJ_SUB;
      fixed[4] = 1'b1;
    end else begin
      fixed[4] = 1'b0;
    end
    return fixed;
  endfunction

  // Select the corrected add or subtract result for this digit
  always_comb begin
    logic [4:0] picked;
    sumRaw  = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin};
    diffRaw = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cin};
    if (mode) begin
      picked = subAdjust(diffRaw);
    end else begin
      picked = addAdjust(sumRaw);
    end
    digit = picked[3:0];
    cout  = picked[4];
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD add/subtract engine. Operands are captured on the
// accept edge and processed one digit per clock, least-significant first.
// A subtract that ends with a borrow runs a second pass (FIX) that turns
// the ten's-complement raw result into a magnitude and flags it negative.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  invalid
);

  localparam int              IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  bcdState_t           state;
  logic [4*DIGITS-1:0] aReg;
  logic [4*DIGITS-1:0] bReg;
  logic                modeReg;
  logic [IDXW-1:0]     idx;
  logic                chain;
  logic [4*DIGITS-1:0] resultReg;
  logic                carryReg;
  logic                negReg;
  logic                invReg;

  logic [3:0]          aDigit;
  logic [3:0]          bDigit;
  logic [3:0]          resDigit;
  logic [3:0]          unitA;
  logic [3:0]          unitB;
  logic                unitMode;
  logic [3:0]          unitDigit;
  logic                unitCout;
  logic                lastDigit;
  logic                enterDone;

  // True when every digit of both operands is a legal decimal digit
  function automatic logic operandsValid(input logic [4*DIGITS-1:0] x,
                                         input logic [4*DIGITS-1:0] y);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!digitValid(x[4*k +: 4]) || !digitValid(y[4*k +: 4])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Pick out the digit currently addressed by the index counter
  always_comb begin
    aDigit   = 4'd0;
    bDigit   = 4'd0;
    resDigit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDXW'(k)) begin
        aDigit   = aReg[4*k +: 4];
        bDigit   = bReg[4*k +: 4];
        resDigit = resultReg[4*k +: 4];
      end
    end
  end

  // Route operands to the shared digit cell: FIX computes 0 - result[idx]
  always_comb begin
    if (state == FIX) begin
      unitA    = 4'd0;
      unitB    = resDigit;
      unitMode = 1'b1;
    end else begin
      unitA    = aDigit;
      unitB    = bDigit;
      unitMode = modeReg;
    end
  end

  bcd_digit_unit uDigit (
    .a_i   (unitA),
    .b_i   (unitB),
    .mode  (unitMode),
    .cin   (chain),
    .digit (unitDigit),
    .cout  (unitCout)
  );

  // Detect the final digit of a pass and whether DONE follows it
  always_comb begin
    lastDigit = (idx == LAST_IDX);
    enterDone = 1'b0;
    if (state == RUN && lastDigit && !(modeReg && unitCout)) begin
      enterDone = 1'b1;
    end
    if (state == FIX && lastDigit) begin
      enterDone = 1'b1;
    end
  end

  // Operand capture; these registers carry data only and need no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      aReg    <= a;
      bReg    <= b;
      modeReg <= mode;
    end
  end

  // Controller, digit index, carry/borrow chain and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      chain     <= 1'b0;
      resultReg <= '0;
      carryReg  <= 1'b0;
      negReg    <= 1'b0;
      invReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            chain     <= 1'b0;
            resultReg <= '0;
            carryReg  <= 1'b0;
            negReg    <= 1'b0;
            invReg    <= !operandsValid(a, b);
            state     <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDXW'(k)) begin
              resultReg[4*k +: 4] <= unitDigit;
            end
          end
          chain <= unitCout;
          if (lastDigit) begin
            if (!modeReg) begin
              carryReg <= unitCout;
              state    <= DONE;
            end else if (!unitCout) begin
              state <= DONE;
            end else begin
              // Raw result is the ten's complement of the magnitude
              negReg <= 1'b1;
              idx    <= '0;
              chain  <= 1'b0;
              state  <= FIX;
            end
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        FIX: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDXW'(k)) begin
              resultReg[4*k +: 4] <= unitDigit;
            end
          end
          chain <= unitCout;
          if (lastDigit) begin
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Illegal operands: computation runs but reports a clean zero
      if (enterDone && invReg) begin
        resultReg <= '0;
        carryReg  <= 1'b0;
        negReg    <= 1'b0;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign result    = resultReg;
  assign carry_out = carryReg;
  assign negative  = negReg;
  assign invalid   = invReg;

endmodule

// File: doc/bcd_addsub_seq.md
# bcd_addsub_seq

Parametrised, digit-serial BCD add/subtract unit for the multi-digit BCD ALU datapath. It accepts two packed DIGITS-wide BCD operands and a mode bit through a ready/start handshake, then processes one digit per clock, least-significant digit first. Subtraction results are signed: a borrow-out triggers a second ten's-complement pass that returns the magnitude plus a negative flag. It replaces per-width combinational digit chains with one reusable sequential engine.

## Interface
- DIGITS, 3, number of BCD digits per operand (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted on a clk edge where start=1 and ready=1.
- mode  in  1  0 = add, 1 = subtract (a − b); captured at accept.
- a  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; captured at accept.
- b  in  4*DIGITS  packed BCD operand, same layout.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; result flags are valid from this cycle until the next accept.
- result  out  4*DIGITS  BCD result (sum mod 10^DIGITS, or |a−b|).
- carry_out  out  1  add overflow (sum ≥ 10^DIGITS); always 0 for subtract.
- negative  out  1  subtract with a < b.
- invalid  out  1  any captured digit of a or b > 9.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: ready=1. On accept, register a, b, mode. Clear digit index, carry/borrow, and result. Set invalid from the captured operands. Go to RUN.
- RUN: each cycle computes digit[idx] of a op b with the running carry/borrow:
  - add: s = a_i + b_i + c; if s > 9, then digit = s + 6 (low 4 bits) and c = 1.
  - sub: 5-bit d = a_i − b_i − bw; if d[4] = 1, then digit = d + 10 (low 4 bits) and bw = 1.
  - Write the digit into result[idx]. At idx = DIGITS−1, exit RUN:
    - add: carry_out = final c; go to DONE.
    - sub with final bw = 0: go to DONE.
    - sub with final bw = 1: negative = 1, clear idx and bw, go to FIX.
- FIX: each cycle computes result[idx] = 0 − result[idx] − bw (BCD subtract rule above), giving 10^DIGITS − raw. Go to DONE after digit DIGITS−1.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs hold.
- invalid=1: computation still runs, but result is forced to all-zero and carry_out/negative to 0 when DONE is entered. invalid holds until the next accept.
- start while ready=0 is ignored and not queued. Operand or mode changes after accept have no effect.
- Reset (any state, including mid-RUN/FIX): state = IDLE, ready = 1, done/result/carry_out/negative/invalid = 0, idx and carry/borrow cleared.

## Timing
- Accept edge = T0. RUN processes digits on edges T1..T_DIGITS.
- Add, or subtract without borrow: done is high in the cycle after edge T_DIGITS (latency DIGITS+1 cycles). ready returns on the following edge.
- Subtract with borrow: FIX adds DIGITS edges; done is high after edge T_2·DIGITS (latency 2·DIGITS+1).
- Minimum accept-to-accept spacing is DIGITS+2 cycles (back-to-back start held high).
- result, carry_out, negative, and invalid are registered outputs. No combinational path runs from inputs to outputs except start → (ignored) while busy.
- Digit index counter width = $clog2(DIGITS), minimum 1 bit. No wrap beyond DIGITS−1.

## Structure
- Shared package bcd_pkg:
  - state enum {IDLE, RUN, FIX, DONE}
  - constants BCD_MAX = 4'd9, BCD_ADJ_ADD = 6, BCD_ADJ_SUB = 10
  - a function checking one digit for validity
- One combinational sub-module, bcd_digit_unit: inputs a_i, b_i, mode, cin; outputs digit, cout. It handles both add (cout = carry) and subtract (cout = borrow). It is instantiated once and shared by RUN and FIX; in FIX it is driven with a_i = 0, b_i = result[idx], mode = 1.
- Top-level bcd_addsub_seq contains the FSM, operand/result registers, and the index counter.

## Test plan
- DIGITS=3, add 123+456 → result 579, carry_out=0, negative=0, done exactly 4 cycles after accept.
- DIGITS=3, add 999+001 → result 000, carry_out=1; add 095+005 → 100 (carry ripple across digits).
- DIGITS=3, sub 456−123 → 333, negative=0, latency 4; sub 123−456 → 333, negative=1, latency 7; sub 000−001 → 001, negative=1.
- Invalid digit: a=0x1A3, b=0x001 → invalid=1, result 000, carry_out=0; the next valid op clears invalid.
- Handshake: start held high continuously → accepts only when ready=1, spaced DIGITS+2 cycles. Operands changed mid-RUN → result unaffected. done is never two consecutive cycles.
- Reset mid-FIX (rst_n=0 for one cycle) → all outputs 0 and ready=1 on the next cycle, no done pulse. Repeat the add/sub checks at DIGITS=1 and DIGITS=6 (999999+1 → 000000, carry_out=1).
